// File: rtl/tank_pkg.sv
// tank_pkg: tile, direction, state and key definitions shared by the tank controller.
package tank_pkg;
  typedef enum logic [2:0] {EMPTY = 3'd0, WALL = 3'd1, BRICK = 3'd2, BASE1 = 3'd3, BASE0 = 3'd4} tile_t;
  typedef enum logic [1:0] {UP, LEFT, DOWN, RIGHT} dir_t;
  typedef enum logic [1:0] {PLAY, RESPAWN, WON, LOST} state_t;
  typedef struct packed {
    logic [1:0] dx;
    logic [1:0] dy;
  } step_t;
  localparam logic [7:0] K0_UP = 8'h52, K0_LEFT = 8'h50, K0_DOWN = 8'h51, K0_RIGHT = 8'h4F, K0_FIRE = 8'h28;
  localparam logic [7:0] K1_UP = 8'h1A, K1_LEFT = 8'h04, K1_DOWN = 8'h16, K1_RIGHT = 8'h07, K1_FIRE = 8'h14;
  // two's-complement unit step; screen y grows downwards
  function automatic step_t dir_step(input dir_t d);
    step_t s;
    s.dx = d == LEFT ? 2'b11 : d == RIGHT ? 2'b01 : 2'b00;
    s.dy = d == UP ? 2'b11 : d == DOWN ? 2'b01 : 2'b00;
    return s;
  endfunction
endpackage

// File: rtl/tank_bullet_slot.sv
// tank_bullet_slot: one bullet's position/direction and its per-frame flight decision.
module tank_bullet_slot
  import tank_pkg::*;
#(
  parameter int MAP_W = 20,
  parameter int MAP_H = 15,
  parameter tile_t ENEMY_BASE = BASE0,
  localparam int XW = $clog2(MAP_W),
  localparam int YW = $clog2(MAP_H),
  localparam int IW = $clog2(MAP_W * MAP_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     spawn,
  input  logic                     gnt,
  input  logic [XW:0]              spawn_x,
  input  logic [YW:0]              spawn_y,
  input  dir_t                     spawn_dir,
  input  logic [XW-1:0]            enemy_x,
  input  logic [YW-1:0]            enemy_y,
  input  logic [MAP_W*MAP_H*3-1:0] map,
  output logic                     valid,
  output logic [XW-1:0]            x,
  output logic [YW-1:0]            y,
  output logic                     brick_req,
  output logic                     hit,
  output logic                     capture,
  output logic [IW-1:0]            idx
);
  // one spare coordinate bit so a step off either edge always decodes as out-of-bounds
  logic valid_q, valid_d, inb, at_enemy, live, adv;
  logic [XW:0] x_q, x_d;
  logic [YW:0] y_q, y_d;
  dir_t dir_q, dir_d;
  tile_t t;
  step_t st;

  always_comb begin
    inb = int'(x_q) < MAP_W && int'(y_q) < MAP_H;
    idx = inb ? IW'(int'(y_q) * MAP_W + int'(x_q)) : '0;
    t = inb ? tile_t'(map[3*idx +: 3]) : WALL;
    at_enemy = x_q == {1'b0, enemy_x} && y_q == {1'b0, enemy_y};
    st = dir_step(dir_q);
    live = valid_q && !at_enemy;
    hit = valid_q && at_enemy;
    brick_req = live && t == BRICK;
    capture = live && t == ENEMY_BASE;
    adv = live && t == EMPTY;
    valid_d = !clr && (spawn || adv || (brick_req && !gnt));
    x_d = spawn ? spawn_x : adv ? x_q + {{(XW-1){st.dx[1]}}, st.dx} : x_q;
    y_d = spawn ? spawn_y : adv ? y_q + {{(YW-1){st.dy[1]}}, st.dy} : y_q;
    dir_d = spawn ? spawn_dir : dir_q;
  end

  always_ff @(posedge clk)
    if (rst) begin
      valid_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      dir_q <= UP;
    end else begin
      valid_q <= valid_d;
      x_q <= x_d;
      y_q <= y_d;
      dir_q <= dir_d;
    end

  assign valid = valid_q;
  assign x = x_q[XW-1:0];
  assign y = y_q[YW-1:0];
endmodule

// File: rtl/tank_ctrl_multi.sv
// tank_ctrl_multi: one tank's movement, fire control, bullet pool arbitration and game state.
module tank_ctrl_multi
  import tank_pkg::*;
#(
  parameter int MAP_W = 20,
  parameter int MAP_H = 15,
  parameter int N_BUL = 4,
  parameter int COOLDOWN = 3,
  parameter int RESPAWN_FR = 30,
  parameter int PLAYER = 0,
  parameter int SPAWN_X = PLAYER != 0 ? 1 : 18,
  parameter int SPAWN_Y = PLAYER != 0 ? 13 : 1,
  parameter int WIN_X = 9,
  parameter int WIN_Y = 7,
  localparam int XW = $clog2(MAP_W),
  localparam int YW = $clog2(MAP_H),
  localparam int IW = $clog2(MAP_W * MAP_H)
) (
  input  logic                        frame_clk,
  input  logic                        Reset,
  input  logic [7:0]                  keycode,
  input  logic [MAP_W*MAP_H*3-1:0]    map,
  input  logic                        loss,
  input  logic                        got_hit,
  input  logic [XW-1:0]               enemy_x,
  input  logic [YW-1:0]               enemy_y,
  output logic                        tank_valid,
  output logic [XW-1:0]               tank_x,
  output logic [YW-1:0]               tank_y,
  output logic [1:0]                  dir,
  output logic [N_BUL-1:0]            bul_valid,
  output logic [N_BUL-1:0][XW-1:0]    bul_x,
  output logic [N_BUL-1:0][YW-1:0]    bul_y,
  output logic                        brick_we,
  output logic [IW-1:0]               brick_idx,
  output logic                        hit_enemy,
  output logic                        win
);
  localparam int CW = $clog2(COOLDOWN + 2);
  localparam int RW = $clog2(RESPAWN_FR + 1);
  localparam logic [7:0] K_UP = PLAYER != 0 ? K1_UP : K0_UP;
  localparam logic [7:0] K_LEFT = PLAYER != 0 ? K1_LEFT : K0_LEFT;
  localparam logic [7:0] K_DOWN = PLAYER != 0 ? K1_DOWN : K0_DOWN;
  localparam logic [7:0] K_RIGHT = PLAYER != 0 ? K1_RIGHT : K0_RIGHT;
  localparam logic [7:0] K_FIRE = PLAYER != 0 ? K1_FIRE : K0_FIRE;

  state_t state_q, state_d;
  dir_t dir_q, dir_d, kdir, ndir;
  logic tank_valid_q, tank_valid_d, brick_we_q, brick_we_d, hit_enemy_q, hit_enemy_d, win_q, win_d;
  logic [XW-1:0] tx_q, tx_d;
  logic [YW-1:0] ty_q, ty_d;
  logic [CW-1:0] cool_q, cool_d;
  logic [RW-1:0] resp_q, resp_d;
  logic [IW-1:0] brick_idx_q, brick_idx_d, m_idx;
  logic [XW:0] mx, fx;
  logic [YW:0] my, fy;
  logic [N_BUL-1:0] free, spawn, req, gnt, hit, capture;
  logic [N_BUL-1:0][IW-1:0] sidx;
  logic is_dir, m_inb, move, fire, lose, cap, hitme, clr, respawn;
  step_t ms, fs;

  always_comb begin
    is_dir = keycode inside {K_UP, K_LEFT, K_DOWN, K_RIGHT};
    kdir = keycode == K_UP ? UP : keycode == K_LEFT ? LEFT : keycode == K_DOWN ? DOWN : RIGHT;
    ndir = state_q == PLAY && is_dir ? kdir : dir_q;
    ms = dir_step(ndir);
    fs = dir_step(dir_q);
    mx = {1'b0, tx_q} + {{(XW-1){ms.dx[1]}}, ms.dx};
    my = {1'b0, ty_q} + {{(YW-1){ms.dy[1]}}, ms.dy};
    fx = {1'b0, tx_q} + {{(XW-1){fs.dx[1]}}, fs.dx};
    fy = {1'b0, ty_q} + {{(YW-1){fs.dy[1]}}, fs.dy};
    m_inb = int'(mx) < MAP_W && int'(my) < MAP_H;
    m_idx = m_inb ? IW'(int'(my) * MAP_W + int'(mx)) : '0;
    move = state_q == PLAY && is_dir && m_inb && tile_t'(map[3*m_idx +: 3]) == EMPTY &&
           !(mx == {1'b0, enemy_x} && my == {1'b0, enemy_y});
    // lowest free slot for a new shot, lowest requester owns the brick port
    free = ~bul_valid;
    fire = state_q == PLAY && keycode == K_FIRE && cool_q == '0 && |free;
    spawn = fire ? free & (~free + N_BUL'(1)) : '0;
    gnt = req & (~req + N_BUL'(1));
    lose = loss && (state_q == PLAY || state_q == RESPAWN);
    cap = state_q == PLAY && |capture;
    hitme = state_q == PLAY && got_hit;
    clr = lose || cap || hitme || state_q != PLAY;
    respawn = state_q == RESPAWN && resp_q == '0;
    state_d = lose ? LOST : cap ? WON : hitme ? RESPAWN : respawn ? PLAY : state_q;
    tank_valid_d = state_d == PLAY || state_d == WON;
    tx_d = state_d == WON ? XW'(WIN_X) : respawn ? XW'(SPAWN_X) : move && !clr ? mx[XW-1:0] : tx_q;
    ty_d = state_d == WON ? YW'(WIN_Y) : respawn ? YW'(SPAWN_Y) : move && !clr ? my[YW-1:0] : ty_q;
    dir_d = respawn ? UP : ndir;
    cool_d = fire ? CW'(COOLDOWN) : cool_q != '0 ? cool_q - CW'(1) : cool_q;
    resp_d = hitme ? RW'(RESPAWN_FR - 1) : state_q == RESPAWN && resp_q != '0 ? resp_q - RW'(1) : resp_q;
    brick_we_d = state_q == PLAY && |req;
    hit_enemy_d = state_q == PLAY && |hit;
    win_d = state_d == WON;
    brick_idx_d = brick_idx_q;
    for (int i = 0; i < N_BUL; i++) if (gnt[i]) brick_idx_d = sidx[i];
  end

  always_ff @(posedge frame_clk)
    if (Reset) begin
      state_q <= PLAY;
      tank_valid_q <= 1'b1;
      tx_q <= XW'(SPAWN_X);
      ty_q <= YW'(SPAWN_Y);
      dir_q <= UP;
      cool_q <= '0;
      resp_q <= '0;
      brick_we_q <= 1'b0;
      brick_idx_q <= '0;
      hit_enemy_q <= 1'b0;
      win_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tank_valid_q <= tank_valid_d;
      tx_q <= tx_d;
      ty_q <= ty_d;
      dir_q <= dir_d;
      cool_q <= cool_d;
      resp_q <= resp_d;
      brick_we_q <= brick_we_d;
      brick_idx_q <= brick_idx_d;
      hit_enemy_q <= hit_enemy_d;
      win_q <= win_d;
    end

  for (genvar i = 0; i < N_BUL; i++) begin : g_slot
    tank_bullet_slot #(
      .MAP_W(MAP_W),
      .MAP_H(MAP_H),
      .ENEMY_BASE(PLAYER != 0 ? BASE1 : BASE0)
    ) u_slot (
      .clk(frame_clk),
      .rst(Reset),
      .clr(clr),
      .spawn(spawn[i]),
      .gnt(gnt[i]),
      .spawn_x(fx),
      .spawn_y(fy),
      .spawn_dir(dir_q),
      .enemy_x(enemy_x),
      .enemy_y(enemy_y),
      .map(map),
      .valid(bul_valid[i]),
      .x(bul_x[i]),
      .y(bul_y[i]),
      .brick_req(req[i]),
      .hit(hit[i]),
      .capture(capture[i]),
      .idx(sidx[i])
    );
  end

  assign tank_valid = tank_valid_q;
  assign tank_x = tx_q;
  assign tank_y = ty_q;
  assign dir = dir_q;
  assign brick_we = brick_we_q;
  assign brick_idx = brick_idx_q;
  assign hit_enemy = hit_enemy_q;
  assign win = win_q;
endmodule

// File: tb/tb_tank_ctrl_multi.sv
// tb_tank_ctrl_multi: directed vectors for tank_ctrl_multi with default parameters (PLAYER 0).
module tb_tank_ctrl_multi;
  logic frame_clk = 1'b0;
  logic Reset = 1'b1;
  logic [7:0] keycode = '0;
  logic [899:0] map = '0;
  logic loss = 1'b0, got_hit = 1'b0;
  logic [4:0] enemy_x = 5'd0;
  logic [3:0] enemy_y = 4'd14;
  logic tank_valid, brick_we, hit_enemy, win;
  logic [4:0] tank_x;
  logic [3:0] tank_y;
  logic [1:0] dir;
  logic [3:0] bul_valid;
  logic [3:0][4:0] bul_x;
  logic [3:0][3:0] bul_y;
  logic [8:0] brick_idx;
  int n_vec = 0, n_err = 0;
  int fire_exp[10] = '{1, 1, 1, 1, 3, 3, 3, 3, 7, 7};
  int zeros;

  always #5 frame_clk = ~frame_clk;

  tank_ctrl_multi dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .keycode(keycode),
    .map(map),
    .loss(loss),
    .got_hit(got_hit),
    .enemy_x(enemy_x),
    .enemy_y(enemy_y),
    .tank_valid(tank_valid),
    .tank_x(tank_x),
    .tank_y(tank_y),
    .dir(dir),
    .bul_valid(bul_valid),
    .bul_x(bul_x),
    .bul_y(bul_y),
    .brick_we(brick_we),
    .brick_idx(brick_idx),
    .hit_enemy(hit_enemy),
    .win(win)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic set_tile(input int x, input int y, input logic [2:0] c);
    map[(y*20+x)*3 +: 3] = c;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    keycode = '0;
    loss = 1'b0;
    got_hit = 1'b0;
    map = '0;
    enemy_x = 5'd0;
    enemy_y = 4'd14;
    step;
    Reset = 1'b0;
  endtask

  initial begin
    do_reset;
    chk("rst_valid", tank_valid, 1);
    chk("rst_x", tank_x, 18);
    chk("rst_y", tank_y, 1);
    chk("rst_dir", dir, 0);
    chk("rst_bul", bul_valid, 0);
    chk("rst_bulx0", bul_x[0], 0);
    chk("rst_brick", brick_we, 0);
    chk("rst_bidx", brick_idx, 0);
    chk("rst_hit", hit_enemy, 0);
    chk("rst_win", win, 0);

    keycode = 8'h50;
    step;
    chk("mv1_x", tank_x, 17);
    chk("mv1_dir", dir, 1);
    step;
    chk("mv2_x", tank_x, 16);
    keycode = 8'h33;
    step;
    chk("nokey_x", tank_x, 16);
    chk("nokey_dir", dir, 1);

    do_reset;
    set_tile(17, 1, 3'd1);
    keycode = 8'h50;
    step;
    chk("wall_x", tank_x, 18);
    chk("wall_dir", dir, 1);

    do_reset;
    enemy_x = 5'd17;
    enemy_y = 4'd1;
    keycode = 8'h50;
    step;
    chk("enemy_block_x", tank_x, 18);

    do_reset;
    keycode = 8'h52;
    step;
    chk("up1_y", tank_y, 0);
    step;
    chk("up_oob_y", tank_y, 0);
    chk("up_oob_dir", dir, 0);

    // hold fire for 10 frames facing left from (17,1)
    do_reset;
    keycode = 8'h50;
    step;
    keycode = 8'h28;
    for (int f = 0; f < 10; f++) begin
      step;
      chk($sformatf("fire_f%0d", f), bul_valid, fire_exp[f]);
    end
    chk("fire_bx0", bul_x[0], 7);
    chk("fire_bx1", bul_x[1], 11);
    chk("fire_bx2", bul_x[2], 15);
    chk("fire_by2", bul_y[2], 1);

    // two bullets land on bricks on the same frame
    do_reset;
    set_tile(10, 1, 3'd2);
    keycode = 8'h50;
    step;
    keycode = 8'h28;
    repeat (5) step;
    keycode = 8'h00;
    step;
    step;
    chk("brk_pre_bx0", bul_x[0], 10);
    chk("brk_pre_bx1", bul_x[1], 14);
    set_tile(14, 1, 3'd2);
    step;
    chk("brk1_we", brick_we, 1);
    chk("brk1_idx", brick_idx, 30);
    chk("brk1_valid", bul_valid, 2);
    chk("brk1_bx1", bul_x[1], 14);
    step;
    chk("brk2_we", brick_we, 1);
    chk("brk2_idx", brick_idx, 34);
    chk("brk2_valid", bul_valid, 0);
    step;
    chk("brk3_we", brick_we, 0);

    // bullet spawned onto the enemy tank
    do_reset;
    enemy_x = 5'd18;
    enemy_y = 4'd0;
    keycode = 8'h28;
    step;
    chk("he_spawn", bul_valid, 1);
    keycode = 8'h00;
    step;
    chk("he_pulse", hit_enemy, 1);
    chk("he_valid", bul_valid, 0);
    step;
    chk("he_end", hit_enemy, 0);

    // capture of the enemy base
    do_reset;
    set_tile(18, 0, 3'd4);
    keycode = 8'h28;
    step;
    chk("win_spawn", bul_valid, 1);
    chk("win_bx", bul_x[0], 18);
    chk("win_by", bul_y[0], 0);
    keycode = 8'h00;
    step;
    chk("win_win", win, 1);
    chk("win_bul", bul_valid, 0);
    chk("win_x", tank_x, 9);
    chk("win_y", tank_y, 7);
    chk("win_tv", tank_valid, 1);
    keycode = 8'h28;
    step;
    chk("win_hold", win, 1);
    chk("win_hold_bul", bul_valid, 0);

    // own base absorbs the bullet silently
    do_reset;
    set_tile(18, 0, 3'd3);
    keycode = 8'h28;
    step;
    keycode = 8'h00;
    step;
    chk("own_base_win", win, 0);
    chk("own_base_bul", bul_valid, 0);

    // capture and loss on the same frame
    do_reset;
    set_tile(18, 0, 3'd4);
    keycode = 8'h28;
    step;
    keycode = 8'h00;
    loss = 1'b1;
    step;
    loss = 1'b0;
    chk("lose_tv", tank_valid, 0);
    chk("lose_win", win, 0);
    chk("lose_bul", bul_valid, 0);
    step;
    chk("lose_hold", tank_valid, 0);

    // got_hit and respawn timing
    do_reset;
    keycode = 8'h50;
    step;
    keycode = 8'h00;
    got_hit = 1'b1;
    step;
    got_hit = 1'b0;
    zeros = tank_valid ? 0 : 1;
    for (int f = 0; f < 29; f++) begin
      keycode = (f % 2 == 0) ? 8'h4F : 8'h28;
      step;
      if (!tank_valid) zeros++;
    end
    keycode = 8'h00;
    chk("resp_frames", zeros, 30);
    chk("resp_bul", bul_valid, 0);
    step;
    chk("resp_tv", tank_valid, 1);
    chk("resp_x", tank_x, 18);
    chk("resp_y", tank_y, 1);
    chk("resp_dir", dir, 0);

    // reset in the middle of respawn
    keycode = 8'h50;
    step;
    keycode = 8'h00;
    got_hit = 1'b1;
    step;
    got_hit = 1'b0;
    repeat (5) step;
    chk("mid_tv0", tank_valid, 0);
    do_reset;
    chk("mid_tv", tank_valid, 1);
    chk("mid_x", tank_x, 18);
    chk("mid_dir", dir, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
